// File: rtl/spi_byte_xfer.sv
// -----------------------------------------------------------------------------
// spi_byte_xfer
//   Single-byte, full-duplex SPI master, mode 0 (SCLK idles low, MISO sampled
//   on the rising SCLK edge, MOSI shifted on the falling edge). A sequencer
//   streams bytes with send_request / processing / data_valid; cs_at_end lets
//   it keep chip-select low across a multi-byte burst.
//
// Build option: define SPI_LSB_FIRST_EN to shift LSB first in both directions
//   (MOSI sends din[0] first, first received bit lands in dout[0]).
//
// Parameters
//   CLK_DIV      clk cycles per SCLK half-period (>= 1)
// Ports
//   clk          in   system clock, all logic on rising edge
//   reset        in   synchronous active-high reset (aborts a transfer)
//   send_request in   start strobe, only honoured while idle
//   din[7:0]     in   byte to transmit, captured at start
//   cs_at_end    in   1: release cs after the byte, 0: keep cs low
//   miso         in   serial data from slave
//   mosi         out  serial data to slave
//   sclk         out  serial clock
//   cs           out  active-low chip select
//   dout[7:0]    out  last received byte
//   data_valid   out  high from end of transfer until next start
//   processing   out  high while a byte is being shifted (16*CLK_DIV cycles)
//   bit_counter  out  bits completed in current/last transfer (0..8)
// -----------------------------------------------------------------------------
module spi_byte_xfer #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_request,
  input  logic [7:0] din,
  input  logic       cs_at_end,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic       cs,
  output logic [7:0] dout,
  output logic       data_valid,
  output logic       processing,
  output logic [3:0] bit_counter
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // S_LOW / S_HIGH are the two SCLK half-periods of the current bit.
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div_cnt;
  logic [7:0]    r_tx, r_rx, r_dout;
  logic [3:0]    r_bit_cnt;
  logic          r_cs, r_dv;
  logic          w_phase_end, w_start, w_rise, w_fall, w_done;

  assign w_phase_end = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (send_request) begin
        w_start     = 1'b1;
        w_state_nxt = S_LOW;
      end
      S_LOW: if (w_phase_end) begin
        w_rise      = 1'b1;
        w_state_nxt = S_HIGH;
      end
      S_HIGH: if (w_phase_end) begin
        w_fall = 1'b1;
        // The 8th falling edge ends the byte; going idle here is what
        // makes a held request produce exactly one idle cycle between bytes.
        if (r_bit_cnt == 4'd7) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LOW;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_dout    <= '0;
      r_bit_cnt <= '0;
      r_cs      <= 1'b1;
      r_dv      <= 1'b0;
    end else begin
      // Half-period counter restarts at each phase boundary and stays
      // cleared while idle so every transfer starts aligned.
      if (r_state == S_IDLE || w_phase_end) r_div_cnt <= '0;
      else                                  r_div_cnt <= r_div_cnt + 1'b1;

      if (w_start) begin
        r_tx      <= din;
        r_bit_cnt <= '0;
        r_cs      <= 1'b0;
        r_dv      <= 1'b0;
      end

`ifdef SPI_LSB_FIRST_EN
      if (w_rise) r_rx <= {miso, r_rx[7:1]};
      if (w_fall) r_tx <= {1'b0, r_tx[7:1]};
`else
      if (w_rise) r_rx <= {r_rx[6:0], miso};
      if (w_fall) r_tx <= {r_tx[6:0], 1'b0};
`endif

      if (w_fall) r_bit_cnt <= r_bit_cnt + 4'd1;

      // r_rx already holds all 8 bits: the last rise precedes this fall.
      if (w_done) begin
        r_dout <= r_rx;
        r_dv   <= 1'b1;
        r_cs   <= cs_at_end;
      end
    end
  end

  assign processing  = (r_state != S_IDLE);
  assign sclk        = (r_state == S_HIGH);
`ifdef SPI_LSB_FIRST_EN
  assign mosi        = processing & r_tx[0];
`else
  assign mosi        = processing & r_tx[7];
`endif
  assign cs          = r_cs;
  assign dout        = r_dout;
  assign data_valid  = r_dv;
  assign bit_counter = r_bit_cnt;

endmodule

// File: tb/tb_spi_byte_xfer.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_xfer
//   Two DUT instances (CLK_DIV=1 and CLK_DIV=3) share one stimulus stream.
//   Each has its own SPI slave (counts SCLK falls, presents rx_byte MSB first,
//   or loops MOSI back) and a transaction-level reference model that predicts
//   every output from "cycles since start" arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_byte_xfer;
`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, send_request = 1'b0, cs_at_end = 1'b1;
  logic [7:0] din = 8'h00, rx_byte = 8'h00;
  logic       lb = 1'b0, chk_en = 1'b0, clr = 1'b0;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = (g == 0) ? 1 : 3;
    logic       miso, mosi, sclk, cs, dv, proc;
    logic [7:0] dout;
    logic [3:0] bc;

    spi_byte_xfer #(.CLK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .send_request(send_request), .din(din),
      .cs_at_end(cs_at_end), .miso(miso), .mosi(mosi), .sclk(sclk), .cs(cs),
      .dout(dout), .data_valid(dv), .processing(proc), .bit_counter(bc)
    );

    // Slave: bit index = SCLK falls seen while selected, modulo 8.
    int         fall_cnt = 0;
    logic       psclk = 1'b0;
    logic [2:0] sidx;
    always @(negedge clk) begin
      if (cs === 1'b1)            fall_cnt <= 0;
      else if (psclk && !sclk)    fall_cnt <= fall_cnt + 1;
      psclk <= sclk;
    end
    assign sidx = 3'(7 - (fall_cnt % 8));
    assign miso = lb ? mosi : rx_byte[sidx];

    // Observers for the directed checks.
    int         starts = 0, pcyc = 0;
    logic [7:0] mcoll = 8'h00;
    logic       pproc = 1'b0;
    always @(negedge clk) begin
      if (clr) begin
        starts <= 0; pcyc <= 0; mcoll <= 8'h00;
      end else begin
        if (proc)            pcyc   <= pcyc + 1;
        if (proc && !pproc)  starts <= starts + 1;
        if (sclk && !psclk)  mcoll  <= {mcoll[6:0], mosi};
      end
      pproc <= proc;
    end

    // Reference model: state is just "busy, cycles since start" plus the
    // values that must hold after a transfer.
    logic       m_busy = 1'b0, m_cs = 1'b1, m_dv = 1'b0;
    int         m_d = 0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00, m_dout = 8'h00;
    logic [3:0] m_bc = 4'd0;
    always @(posedge clk) begin
      if (reset) begin
        m_busy <= 1'b0; m_cs <= 1'b1; m_dv <= 1'b0; m_dout <= 8'h00; m_bc <= 4'd0;
      end else if (m_busy) begin
        if (m_d + 1 == 16 * DIV) begin
          m_busy <= 1'b0; m_dv <= 1'b1; m_bc <= 4'd8; m_dout <= m_rx; m_cs <= cs_at_end;
        end else begin
          m_d <= m_d + 1;
        end
      end else if (send_request) begin
        m_busy <= 1'b1; m_d <= 0; m_tx <= din; m_dv <= 1'b0; m_bc <= 4'd0; m_cs <= 1'b0;
        m_rx   <= lb ? din : (LSB ? rev8(rx_byte) : rx_byte);
      end
    end

    always @(negedge clk) begin
      logic       e_proc, e_sclk, e_mosi, e_cs, e_dv;
      logic [3:0] e_bc;
      int         b;
      if (chk_en) begin
        if (m_busy) begin
          b      = m_d / (2 * DIV);
          e_proc = 1'b1;
          e_sclk = ((m_d / DIV) % 2) != 0;
          e_bc   = 4'(b);
          e_mosi = LSB ? m_tx[b] : m_tx[7-b];
          e_cs   = 1'b0;
          e_dv   = 1'b0;
        end else begin
          e_proc = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0;
          e_bc   = m_bc; e_cs = m_cs;  e_dv = m_dv;
        end
        chk($sformatf("cycle u%0d {proc,sclk,mosi,cs,dv,bc,dout}", g),
            {15'd0, proc, sclk, mosi, cs, dv, bc, dout},
            {15'd0, e_proc, e_sclk, e_mosi, e_cs, e_dv, e_bc, m_dout});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((u[0].proc || u[1].proc) && n < lim) begin tick(); n++; end
    chk("idle_within_bound", {u[0].proc, u[1].proc}, 0);
  endtask

  task automatic pulse_req();
    send_request = 1'b1; tick(); send_request = 1'b0;
  endtask

  task automatic clear_obs();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    tick(); chk_en = 1'b1; tick(); tick();
    chk("reset {cs,sclk,proc,dv,bc,dout}",
        {u[0].cs, u[0].sclk, u[0].proc, u[0].dv, u[0].bc, u[0].dout}, {4'b1000, 4'd0, 8'h00});
    reset = 1'b0; tick();

    // A5 out, 3C in, release cs; din changes after start are ignored.
    din = 8'hA5; rx_byte = 8'h3C; cs_at_end = 1'b1; lb = 1'b0;
    clear_obs(); pulse_req(); din = 8'h5A;
    wait_idle(200);
    chk("a5 dout u0", u[0].dout, 8'h3C);
    chk("a5 dout u1", u[1].dout, 8'h3C);
    chk("a5 {dv,cs,bc} u0", {u[0].dv, u[0].cs, u[0].bc}, {2'b11, 4'd8});
    chk("a5 proc cycles u0", u[0].pcyc, 16);
    chk("a5 proc cycles u1", u[1].pcyc, 48);
    chk("a5 mosi bits u0", u[0].mcoll, 8'hA5);

    // Loopback 03, hold cs.
    din = 8'h03; lb = 1'b1; cs_at_end = 1'b0;
    pulse_req(); wait_idle(200);
    chk("loop dout u0", u[0].dout, 8'h03);
    chk("loop cs u0", u[0].cs, 1'b0);
    chk("loop dout u1", u[1].dout, 8'h03);

    // FF out, 0F in; LSB build sees the slave's bits reversed.
    din = 8'hFF; lb = 1'b0; rx_byte = 8'h0F; cs_at_end = 1'b1;
    pulse_req(); wait_idle(200);
    chk("ff dout u1", u[1].dout, LSB ? 8'hF0 : 8'h0F);
    chk("ff mosi-high u1 cs", u[1].cs, 1'b1);

    // Second pulse mid-transfer must be ignored.
    din = 8'h96; rx_byte = 8'h61;
    clear_obs(); pulse_req();
    repeat (5) tick();
    pulse_req(); wait_idle(200);
    chk("ignored req starts u0", u[0].starts, 1);
    chk("ignored req starts u1", u[1].starts, 1);
    chk("ignored req bc u0", u[0].bc, 4'd8);

    // Held request: u0 fits three bytes into 40 cycles, u1 one.
    cs_at_end = 1'b0; clear_obs();
    send_request = 1'b1; repeat (40) tick(); send_request = 1'b0;
    wait_idle(200);
    chk("held starts u0", u[0].starts, 3);
    chk("held starts u1", u[1].starts, 1);

    // Reset when u0 is at bit 3.
    cs_at_end = 1'b1; pulse_req();
    for (int n = 0; n < 50 && u[0].bc != 4'd3; n++) tick();
    chk("reach bit3 u0", u[0].bc, 4'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset {cs,sclk,proc,dv,dout} u0",
        {u[0].cs, u[0].sclk, u[0].proc, u[0].dv, u[0].dout}, {4'b1000, 8'h00});
    chk("midreset {cs,proc} u1", {u[1].cs, u[1].proc}, 2'b10);

    // Randomized traffic.
    for (int c = 0; c < 40; c++) begin
      wait_idle(200);
      lb = 1'($urandom % 2); rx_byte = 8'($urandom);
      for (int k = 0; k < 80; k++) begin
        send_request = ($urandom % 3) == 0;
        din          = 8'($urandom);
        cs_at_end    = 1'($urandom);
        reset        = ($urandom % 150) == 0;
        tick();
      end
      send_request = 1'b0; reset = 1'b0;
    end
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
